window_sipo: RTL
================

Name: window_sipo

Overview:
- Parametrised serial-in/parallel-out window assembler for the convolution datapath. Successor to the fixed 3-tap, free-running shift register.
- Collects N multi-channel pixel beats into one N-tap window and emits it with a programmable stride.
- Valid/ready handshakes on both sides; row boundaries via in_last, so windows never span rows.
- Sits between the pixel streamer and the MAC array.

Parameters:
- N, 3, window taps (beats per window), N >= 2.
- PB, 8, bits per pixel channel.
- CH, 2, channels packed per beat.
- SW, $clog2(N)+1, width of the stride input (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stride  in  SW  window step in beats, 1..N; 0 is treated as 1.
- in_data  in  CH*PB  pixel beat.
- in_valid  in  1  beat valid.
- in_last  in  1  beat is last of row.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_data  out  N*CH*PB  window; newest beat in the top slot, oldest in bits [CH*PB-1:0].
- out_valid  out  1  window valid.
- out_last  out  1  window contains the row's last beat.
- out_ready  in  1  window consumed when out_valid && out_ready.

Behaviour:
- Reset: out_valid=0, out_last=0, out_data=0, shift register=0, fill=0, phase=0.
- in_ready = !out_valid || out_ready (combinational). Back-to-back streaming: 1 beat/cycle.
- On accept: window <= {in_data, window[top N-1 slots]}. fill increments, saturating at N. If phase != 0, phase decrements.
- Emit: if post-update fill == N and phase == 0:
  - out_data <= new window; out_valid <= 1; out_last <= in_last.
  - phase <= eff_stride-1.
  - Latency: window visible the cycle after the Nth beat is accepted.
- Stride sampling: eff_stride is latched on the first beat of a row (fill == 0). Changes mid-row are ignored.
- out_valid && !out_ready: out_data and out_last are held stable; in_ready=0, so no beat is lost or overwritten.
- out_valid && out_ready with no new emit: out_valid <= 0.
- Consume and new emit in the same cycle: out_valid stays 1 with the new data.
- in_last accepted: after any emit on that beat, fill <= 0 and phase <= 0.
  - If fill < N or phase != 0 on that beat, no window is produced; the partial row is dropped silently.
- Rows shorter than N produce no output.
- rst mid-row: all state clears; a pending window is discarded.
- Stride > N is clamped to N.

Optional Feature:
- Macro: WINDOW_SIPO_IDX_EN.
- Defined:
  - Adds output out_idx [15:0], the window index within the current row, registered alongside out_data.
  - First window of a row has index 0; the index increments on each emit, wraps at 65535, and returns to 0 after in_last and after reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package conveng_pkg:
  - pixel_t (PB bits)
  - beat_t (CH pixel_t)
  - window_t (N beat_t)
  - stride width function
  - default N/PB/CH constants
- One sub-module, win_shift_reg: N-slot shift register plus saturating fill counter.
- Stride phase, handshake and output register stay in window_sipo.

Test Plan (N=3, PB=8, CH=2):
1. Basic fill: stride=1, out_ready=1, beats 0x0101,0x0202,0x0303 then 0x0404.
   -> out_valid first asserts the cycle after beat 3, out_data=0x030302020101.
   -> Next window 0x040403030202.
2. Stride 2: stride=2, 7 beats 0x0101..0x0707, last on beat 7.
   -> Windows end at beats 3, 5, 7 (0x0303.., 0x0505.., 0x0707..).
   -> Only the third window has out_last=1.
3. Backpressure: out_ready=0 for 4 cycles after the first window.
   -> in_ready=0 and out_data stable for those cycles.
   -> On release, windows resume with no beat skipped or duplicated.
4. Row boundary: row of 4 beats (in_last on beat 4), then new row 0x1111,0x1212,0x1313.
   -> Window {4,3,2} has out_last=1.
   -> Next window appears only after 0x1313: 0x131312121111.
5. Reset and short row: rst after 2 beats -> no output until 3 fresh beats. Row of 2 beats with in_last -> no window.
6. Stride corners: stride=0 behaves as stride 1; stride=3 gives non-overlapping windows {3,2,1},{6,5,4}. With WINDOW_SIPO_IDX_EN, out_idx = 0,1 and returns to 0 after in_last.

Source files
------------

// File: rtl/conveng_pkg.sv
// Shared types and defaults for the convolution datapath window assembler.
package conveng_pkg;

   localparam int N_DEF  = 3;
   localparam int PB_DEF = 8;
   localparam int CH_DEF = 2;

   typedef logic   [PB_DEF-1:0] pixel_t;
   typedef pixel_t [CH_DEF-1:0] beat_t;
   typedef beat_t  [N_DEF-1:0]  window_t;

   // Width needed to carry a stride value 0..n.
   function automatic int stride_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/window_sipo_win_shift_reg.sv
// N-slot beat shift register with a saturating fill counter; exposes the
// post-shift window so the parent can register it in the same cycle.
module win_shift_reg #(
   parameter int N  = 3,
   parameter int BW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            shift,
   input  logic            clr_fill,
   input  logic [BW-1:0]   din,
   output logic [N*BW-1:0] window_next,
   output logic            full_next,
   output logic            fill_empty
);

   localparam int FW = $clog2(N + 1);

   logic [N*BW-1:0] window;
   logic [FW-1:0]   fill;
   logic [FW-1:0]   fill_next;

   assign window_next = shift ? {din, window[N*BW-1:BW]} : window;
   assign fill_empty  = (fill == '0);

   always_comb begin
      fill_next = fill;
      if (shift && (fill != FW'(N)))
         fill_next = fill + FW'(1);
   end

   assign full_next = (fill_next == FW'(N));

   always_ff @(posedge clk) begin
      if (rst) begin
         window <= '0;
         fill   <= '0;
      end else begin
         window <= window_next;
         if (clr_fill)
            fill <= '0;
         else
            fill <= fill_next;
      end
   end

endmodule

// File: rtl/window_sipo.sv
// Serial-in/parallel-out N-tap window assembler with programmable stride and
// row-aware handshakes. Optional out_idx port under WINDOW_SIPO_IDX_EN.
module window_sipo
   import conveng_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int PB = PB_DEF,
   parameter int CH = CH_DEF,
   parameter int SW = stride_width(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SW-1:0]     stride,
   input  logic [CH*PB-1:0]  in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic [N*CH*PB-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   input  logic              out_ready
`ifdef WINDOW_SIPO_IDX_EN
   ,output logic [15:0]      out_idx
`endif
);

   localparam int BW = CH * PB;

   logic            accept;
   logic            emit;
   logic            full_next;
   logic            fill_empty;
   logic [N*BW-1:0] window_next;
   logic [SW-1:0]   stride_c;
   logic [SW-1:0]   eff_stride;
   logic [SW-1:0]   phase;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   // Phase is tested before its own decrement so stride s yields s-1 skipped beats.
   assign emit     = accept && full_next && (phase == '0);

   always_comb begin
      stride_c = stride;
      if (stride == '0)
         stride_c = SW'(1);
      else if (int'(stride) > N)
         stride_c = SW'(N);
   end

   win_shift_reg #(
      .N  (N),
      .BW (BW)
   ) u_shift (
      .clk         (clk),
      .rst         (rst),
      .shift       (accept),
      .clr_fill    (accept && in_last),
      .din         (in_data),
      .window_next (window_next),
      .full_next   (full_next),
      .fill_empty  (fill_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         eff_stride <= SW'(1);
         phase      <= '0;
      end else if (accept) begin
         if (fill_empty)
            eff_stride <= stride_c;
         if (in_last)
            phase <= '0;
         else if (emit)
            phase <= eff_stride - SW'(1);
         else if (phase != '0)
            phase <= phase - SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (emit) begin
         out_data  <= window_next;
         out_valid <= 1'b1;
         out_last  <= in_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

`ifdef WINDOW_SIPO_IDX_EN
   logic [15:0] idx_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_cnt <= '0;
         out_idx <= '0;
      end else if (accept) begin
         if (emit)
            out_idx <= idx_cnt;
         if (in_last)
            idx_cnt <= '0;
         else if (emit)
            idx_cnt <= idx_cnt + 16'd1;
      end
   end
`endif

endmodule
